// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the RISC-V divide sequencer.
package div_pkg;

    localparam int XLEN        = 32;
    localparam int DIV_TIMEOUT = 64;

    localparam logic [XLEN-1:0] DIV_OVF_Q  = 32'h8000_0000;
    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5,
        S_DRAIN = 3'd6
    } div_state_e;

    function automatic logic [XLEN-1:0] div_neg(input logic [XLEN-1:0] x, input logic en);
        return en ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// RISC-V sign fix-up of an unsigned core result: quotient sign is the XOR of
// the operand signs, remainder sign follows the dividend.
module div_sign_fix
    import div_pkg::*;
(
    input  logic [XLEN-1:0] i_qu,
    input  logic [XLEN-1:0] i_ru,
    input  logic            i_neg_a,
    input  logic            i_neg_b,
    output logic [XLEN-1:0] o_q,
    output logic [XLEN-1:0] o_r
);

    assign o_q = div_neg(i_qu, i_neg_a ^ i_neg_b);
    assign o_r = div_neg(i_ru, i_neg_a);

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer in front of the iterative unsigned divider: special cases,
// magnitude conversion, core handshake, sign fix-up and a one-entry result cache.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            div_start,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_status,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    output logic            timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    div_state_e      r_state;
    div_op_e         r_op;
    logic [XLEN-1:0] r_rs1, r_rs2, r_mag_a, r_mag_b;
    logic [XLEN-1:0] r_qu, r_ru, r_q, r_r;
    logic            r_signed, r_neg_a, r_neg_b;
    logic            r_seen_busy, r_timeout_err;
    logic [CNT_W-1:0] r_cnt;

    logic            r_c_valid, r_c_signed;
    logic [XLEN-1:0] r_c_rs1, r_c_rs2, r_c_q, r_c_r;

    logic            w_accept, w_signed, w_neg_a, w_neg_b;
    logic            w_cache_hit, w_cnt_exp, w_core_done, w_is_rem;
    logic [XLEN-1:0] w_fix_q, w_fix_r;

    // Flush wins over a same-cycle accept.
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_signed    = (in_op == DIV_OP_DIV) || (in_op == DIV_OP_REM);
    assign w_neg_a     = w_signed && in_rs1[XLEN-1];
    assign w_neg_b     = w_signed && in_rs2[XLEN-1];
    assign w_cache_hit = r_c_valid && (r_c_rs1 == r_rs1) && (r_c_rs2 == r_rs2)
                         && (r_c_signed == r_signed);
    assign w_cnt_exp   = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_core_done = r_seen_busy && !div_status;
    assign w_is_rem    = (r_op == DIV_OP_REM) || (r_op == DIV_OP_REMU);

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE) && !flush;
    assign out_result   = (r_state == S_DONE) ? (w_is_rem ? r_r : r_q) : '0;
    // A flush in START suppresses the pulse, so the core is never started for a killed op.
    assign div_start    = (r_state == S_START) && !div_status && !flush;
    assign div_dividend = r_mag_a;
    assign div_divisor  = r_mag_b;
    assign timeout_err  = r_timeout_err;

    div_sign_fix u_sign_fix (
        .i_qu    (r_qu),
        .i_ru    (r_ru),
        .i_neg_a (r_neg_a),
        .i_neg_b (r_neg_b),
        .o_q     (w_fix_q),
        .o_r     (w_fix_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= DIV_OP_DIV;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_mag_a       <= '0;
            r_mag_b       <= '0;
            r_qu          <= '0;
            r_ru          <= '0;
            r_q           <= '0;
            r_r           <= '0;
            r_signed      <= 1'b0;
            r_neg_a       <= 1'b0;
            r_neg_b       <= 1'b0;
            r_seen_busy   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
            r_c_valid     <= 1'b0;
            r_c_signed    <= 1'b0;
            r_c_rs1       <= '0;
            r_c_rs2       <= '0;
            r_c_q         <= '0;
            r_c_r         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= div_op_e'(in_op);
                        r_rs1    <= in_rs1;
                        r_rs2    <= in_rs2;
                        r_signed <= w_signed;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_mag_a  <= div_neg(in_rs1, w_neg_a);
                        r_mag_b  <= div_neg(in_rs2, w_neg_b);
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_rs2 == '0) begin
                        r_q     <= DIV_ZERO_Q;
                        r_r     <= r_rs1;
                        r_state <= S_DONE;
                    end else if (r_signed && (r_rs1 == DIV_OVF_Q) && (r_rs2 == '1)) begin
                        r_q     <= DIV_OVF_Q;
                        r_r     <= '0;
                        r_state <= S_DONE;
                    end else if (w_cache_hit) begin
                        r_q     <= r_c_q;
                        r_r     <= r_c_r;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (!div_status) begin
                        r_cnt       <= '0;
                        r_seen_busy <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_seen_busy <= r_seen_busy | div_status;
                    r_cnt       <= r_cnt + CNT_W'(1);
                    if (flush) begin
                        r_state <= S_DRAIN;
                    end else if (w_core_done) begin
                        r_qu    <= div_quotient;
                        r_ru    <= div_remainder;
                        r_state <= S_FIX;
                    end else if (w_cnt_exp) begin
                        r_timeout_err <= 1'b1;
                        r_q           <= '0;
                        r_r           <= '0;
                        r_state       <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    // The core cannot be aborted; let it finish and drop the result.
                    r_seen_busy <= r_seen_busy | div_status;
                    r_cnt       <= r_cnt + CNT_W'(1);
                    if (w_core_done) begin
                        r_state <= S_IDLE;
                    end else if (w_cnt_exp) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_FIX: begin
                    r_q        <= w_fix_q;
                    r_r        <= w_fix_r;
                    r_c_valid  <= 1'b1;
                    r_c_signed <= r_signed;
                    r_c_rs1    <= r_rs1;
                    r_c_rs2    <= r_rs2;
                    r_c_q      <= w_fix_q;
                    r_c_r      <= w_fix_r;
                    r_state    <= flush ? S_IDLE : S_DONE;
                end
                S_DONE: begin
                    if (flush || out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing front-end for the iterative unsigned divider core in the ALU/execute stage.
- Accepts RISC-V DIV/DIVU/REM/REMU requests from the execute pipeline over a valid/ready handshake and resolves the divide-by-zero and signed-overflow special cases locally.
- Converts signed operands to magnitudes, drives the core's start/status handshake, then applies the RISC-V sign fix-up and presents the selected result back to the pipeline.
- Holds a one-entry last-result cache so that a DIV/REM pair on identical operands costs a single core run.

Parameters:
- XLEN, `REG_SIZE (32): operand and result width, taken from inst_defs.
- TIMEOUT, 64: maximum cycles in WAIT before the error flag is raised.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  2  operation select: div_op_e (DIV=0, DIVU=1, REM=2, REMU=3)
- in_rs1  in  XLEN  dividend
- in_rs2  in  XLEN  divisor
- flush  in  1  kill the in-flight request (branch mispredict or trap)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  XLEN  quotient or remainder, as selected by in_op
- div_start  out  1  one-cycle start pulse to the core
- div_dividend  out  XLEN  dividend magnitude sent to the core
- div_divisor  out  XLEN  divisor magnitude sent to the core
- div_status  in  1  core busy
- div_quotient  in  XLEN  core unsigned quotient
- div_remainder  in  XLEN  core unsigned remainder
- timeout_err  out  1  sticky; core never completed within TIMEOUT

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, div_start=0, div_dividend=0, div_divisor=0, timeout_err=0, cache invalid.
- Accept: a request is taken when in_valid && in_ready. Op, rs1, rs2 and signedness are registered on the accept edge.
- signed = (op==DIV || op==REM). neg_a = signed & rs1[31]. neg_b = signed & rs2[31].
- Magnitudes: magnitude = neg ? (~x + 1) : x. |0x80000000| = 0x80000000, which the core treats as unsigned.
- FSM states: IDLE, CHECK, START, WAIT, FIX, DONE, DRAIN.
- IDLE: in_ready=1; on accept go to CHECK.
- CHECK (1 cycle), in priority order:
  - rs2==0: Q=0xFFFFFFFF, R=rs1; go to DONE.
  - signed && rs1==0x80000000 && rs2==0xFFFFFFFF: Q=0x80000000, R=0; go to DONE.
  - Cache hit (valid, same rs1, rs2 and signedness): load the cached Q and R; go to DONE.
  - Otherwise go to START.
  - The three special cases never assert div_start.
- START: drive the magnitudes and assert div_start for exactly one cycle, only while div_status==0. If div_status==1, hold in START. Then go to WAIT.
- WAIT: completion is div_status observed high and then low. The core's Q and R are captured on the first cycle div_status reads low after having been high. Go to FIX.
- FIX (1 cycle):
  - Q = (neg_a ^ neg_b) ? -Qu : Qu.
  - R = neg_a ? -Ru : Ru (remainder sign follows the dividend).
  - Write the cache, then go to DONE.
- DONE: out_valid=1; out_result = Q for DIV/DIVU, R for REM/REMU. Hold stable while out_ready==0. On out_ready go to IDLE.
- Latency after accept: special case or cache hit, out_valid at cycle 2. Core run: core cycles + 4.
- Throughput: in_ready=0 in every state except IDLE. No request is accepted in the same cycle a result is consumed.
- Flush:
  - In CHECK, START (before the pulse) or DONE: return to IDLE with no out_valid.
  - In WAIT, or START after the pulse: go to DRAIN. The core has no abort, so DRAIN waits for div_status to fall, discards the result without writing the cache, then goes to IDLE.
  - Flush in IDLE is ignored. Flush and accept in the same cycle: flush wins and the request is dropped.
- Timeout: a counter runs in WAIT and DRAIN. When it reaches TIMEOUT: set timeout_err (sticky until reset), force out_result=0, and go to DONE (or to IDLE if draining).
- Cache: invalidated by reset. Any accepted request with different operands replaces it once its core run completes.
- Reset mid-operation: the FSM and cache clear immediately. The core is reset by the same reset signal.

Decomposition:
- Package div_pkg: div_op_e, div_state_e, the constants DIV_OVF_Q=32'h80000000 and DIV_ZERO_Q='1, and a function for conditional two's-complement negate.
- One sub-module, div_sign_fix: purely combinational FIX arithmetic (magnitudes in, signed Q/R out) for reuse by a future DIVW path. The FSM and cache stay in the top module.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> one div_start with magnitudes 7/2; out_result=0xFFFFFFFD. Then REM on the same operands -> 0xFFFFFFFF via cache hit, no div_start.
- DIVU rs1=0x1234, rs2=0 -> out_valid at cycle 2 with 0xFFFFFFFF, div_start never asserted. REMU on the same operands -> 0x1234.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0, no div_start.
- REM rs1=7, rs2=-2 -> 1; REM rs1=-7, rs2=-2 -> 0xFFFFFFFF (remainder sign follows the dividend).
- Flush two cycles into WAIT -> no out_valid, in_ready=0 until div_status falls. Next DIVU 100/7 -> 14.
- out_ready held low 5 cycles in DONE -> out_valid and out_result stable. Separately, div_status stuck high -> timeout_err=1 after 64 cycles and out_result=0.
